// File: rtl/arp_pkg.sv
// Shared constants, field offsets, FSM state type and frame-byte helpers for the ARP requester.
package arp_pkg;

  localparam logic [15:0] ETHERTYPE_ARP    = 16'h0806;
  localparam logic [15:0] ARP_OPER_REQUEST = 16'd1;
  localparam logic [15:0] ARP_OPER_REPLY   = 16'd2;
  localparam int unsigned ARP_FRAME_BYTES  = 60;

  localparam logic [5:0] OFF_SRC_MAC    = 6'd6;
  localparam logic [5:0] OFF_ETHERTYPE  = 6'd12;
  localparam logic [5:0] OFF_ARP_HDR    = 6'd14;
  localparam logic [5:0] OFF_OPER       = 6'd20;
  localparam logic [5:0] OFF_SHA        = 6'd22;
  localparam logic [5:0] OFF_SPA        = 6'd28;
  localparam logic [5:0] OFF_THA        = 6'd32;
  localparam logic [5:0] OFF_TPA        = 6'd38;
  localparam logic [5:0] OFF_LAST_FIELD = 6'd41;
  localparam logic [5:0] LAST_BYTE      = 6'(ARP_FRAME_BYTES - 1);

  // htype 0001, ptype 0800, hlen 06, plen 04
  localparam logic [47:0] ARP_FIXED_HDR = 48'h0001_0800_0604;

  typedef enum logic [1:0] {StIdle, StSend, StWait, StDone} arp_req_state_t;

  // Byte pos (0 = most significant) of a len-byte big-endian field.
  function automatic logic [7:0] field_byte(input logic [47:0] field, input int len,
                                            input int pos);
    logic [47:0] sh;
    sh = field >> (8 * (len - 1 - pos));
    return sh[7:0];
  endfunction

  function automatic logic [7:0] arp_tx_byte(input logic [5:0] idx, input logic [47:0] mac,
                                             input logic [31:0] ip, input logic [31:0] tgt);
    int i;
    logic [7:0] b;
    i = int'(idx);
    b = 8'h00;
    if (i < int'(OFF_SRC_MAC))        b = 8'hff;
    else if (i < int'(OFF_ETHERTYPE)) b = field_byte(mac, 6, i - int'(OFF_SRC_MAC));
    else if (i < int'(OFF_ARP_HDR))   b = field_byte({32'd0, ETHERTYPE_ARP}, 2,
                                                     i - int'(OFF_ETHERTYPE));
    else if (i < int'(OFF_OPER))      b = field_byte(ARP_FIXED_HDR, 6, i - int'(OFF_ARP_HDR));
    else if (i < int'(OFF_SHA))       b = field_byte({32'd0, ARP_OPER_REQUEST}, 2,
                                                     i - int'(OFF_OPER));
    else if (i < int'(OFF_SPA))       b = field_byte(mac, 6, i - int'(OFF_SHA));
    else if (i < int'(OFF_THA))       b = field_byte({16'd0, ip}, 4, i - int'(OFF_SPA));
    else if (i < int'(OFF_TPA))       b = 8'h00;
    else if (i <= int'(OFF_LAST_FIELD)) b = field_byte({16'd0, tgt}, 4, i - int'(OFF_TPA));
    return b;
  endfunction

endpackage

// File: rtl/arp_reply_parser.sv
// Receive-side ARP reply filter: flags a reply to our request on its TLAST beat and keeps its SHA.
module arp_reply_parser
  import arp_pkg::*;
(
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic [7:0]  in_r_TDATA,
  input  logic        in_r_TVALID,
  input  logic        in_r_TKEEP,
  input  logic        in_r_TLAST,
  input  logic [31:0] target_ip,
  input  logic [47:0] own_mac,
  input  logic [31:0] own_ip,
  output logic        match,
  output logic [47:0] sha
);

  logic [5:0]  idx_q;
  logic        bad_q;
  logic [47:0] sha_q;
  int          idx_int;
  logic        check_en;
  logic [7:0]  exp_byte;
  logic        byte_en;
  logic        bad_now;

  assign idx_int = int'(idx_q);
  assign byte_en = in_r_TVALID && in_r_TKEEP;

  always_comb begin
    check_en = 1'b0;
    exp_byte = 8'h00;
    if (idx_int >= int'(OFF_ETHERTYPE) && idx_int < int'(OFF_ETHERTYPE) + 2) begin
      check_en = 1'b1;
      exp_byte = field_byte({32'd0, ETHERTYPE_ARP}, 2, idx_int - int'(OFF_ETHERTYPE));
    end else if (idx_int >= int'(OFF_OPER) && idx_int < int'(OFF_OPER) + 2) begin
      check_en = 1'b1;
      exp_byte = field_byte({32'd0, ARP_OPER_REPLY}, 2, idx_int - int'(OFF_OPER));
    end else if (idx_int >= int'(OFF_SPA) && idx_int < int'(OFF_SPA) + 4) begin
      check_en = 1'b1;
      exp_byte = field_byte({16'd0, target_ip}, 4, idx_int - int'(OFF_SPA));
    end else if (idx_int >= int'(OFF_THA) && idx_int < int'(OFF_THA) + 6) begin
      check_en = 1'b1;
      exp_byte = field_byte(own_mac, 6, idx_int - int'(OFF_THA));
    end else if (idx_int >= int'(OFF_TPA) && idx_int < int'(OFF_TPA) + 4) begin
      check_en = 1'b1;
      exp_byte = field_byte({16'd0, own_ip}, 4, idx_int - int'(OFF_TPA));
    end
  end

  // The TLAST beat's own byte counts, so fold the live comparison into the verdict.
  assign bad_now = byte_en && check_en && (in_r_TDATA != exp_byte);
  assign match   = in_r_TVALID && in_r_TLAST && !bad_q && !bad_now &&
                   (idx_q >= OFF_LAST_FIELD);
  assign sha     = sha_q;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      idx_q <= '0;
      bad_q <= 1'b0;
      sha_q <= '0;
    end else begin
      if (byte_en && idx_q >= OFF_SHA && idx_q < OFF_SPA) sha_q <= {sha_q[39:0], in_r_TDATA};
      if (in_r_TVALID && in_r_TLAST) begin
        idx_q <= '0;
        bad_q <= 1'b0;
      end else begin
        if (byte_en && idx_q != 6'd63) idx_q <= idx_q + 6'd1;
        if (bad_now) bad_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/arp_requester.sv
// ARP initiator: broadcasts a request for a target IPv4 address, retries on timeout and
// returns the resolved MAC from the matching reply.
module arp_requester
  import arp_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic [47:0] config_hw_addr,
  input  logic [31:0] config_ip_addr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_ip,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_hit,
  output logic [47:0] res_mac,
  output logic [7:0]  out_r_TDATA,
  output logic        out_r_TVALID,
  input  logic        out_r_TREADY,
  output logic        out_r_TKEEP,
  output logic        out_r_TLAST,
  input  logic [7:0]  in_r_TDATA,
  input  logic        in_r_TVALID,
  output logic        in_r_TREADY,
  input  logic        in_r_TKEEP,
  input  logic        in_r_TLAST
);

  localparam logic [31:0] TimerLast = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  RetryMax  = 8'(MAX_RETRIES);

  arp_req_state_t state_q;
  logic [47:0]    own_mac_q;
  logic [31:0]    own_ip_q;
  logic [31:0]    target_ip_q;
  logic [5:0]     tx_idx_q;
  logic [31:0]    timer_q;
  logic [7:0]     retries_q;
  logic           tx_valid_q;
  logic           tx_last_q;
  logic [7:0]     tx_data_q;
  logic           res_valid_q;
  logic           res_hit_q;
  logic [47:0]    res_mac_q;
  logic           match;
  logic [47:0]    sha;

  arp_reply_parser u_parser (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .in_r_TDATA  (in_r_TDATA),
    .in_r_TVALID (in_r_TVALID),
    .in_r_TKEEP  (in_r_TKEEP),
    .in_r_TLAST  (in_r_TLAST),
    .target_ip   (target_ip_q),
    .own_mac     (own_mac_q),
    .own_ip      (own_ip_q),
    .match       (match),
    .sha         (sha)
  );

  assign req_ready    = (state_q == StIdle) && !ap_rst;
  assign res_valid    = res_valid_q;
  assign res_hit      = res_hit_q;
  assign res_mac      = res_mac_q;
  assign out_r_TDATA  = tx_data_q;
  assign out_r_TVALID = tx_valid_q;
  assign out_r_TLAST  = tx_last_q;
  assign out_r_TKEEP  = 1'b1;
  assign in_r_TREADY  = 1'b1;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= StIdle;
      own_mac_q   <= '0;
      own_ip_q    <= '0;
      target_ip_q <= '0;
      tx_idx_q    <= '0;
      timer_q     <= '0;
      retries_q   <= '0;
      tx_valid_q  <= 1'b0;
      tx_last_q   <= 1'b0;
      tx_data_q   <= '0;
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_mac_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            own_mac_q   <= config_hw_addr;
            own_ip_q    <= config_ip_addr;
            target_ip_q <= req_ip;
            retries_q   <= '0;
            tx_idx_q    <= '0;
            tx_valid_q  <= 1'b1;
            tx_last_q   <= 1'b0;
            tx_data_q   <= arp_tx_byte(6'd0, config_hw_addr, config_ip_addr, req_ip);
            state_q     <= StSend;
          end
        end
        StSend: begin
          if (match) begin
            tx_valid_q  <= 1'b0;
            tx_last_q   <= 1'b0;
            tx_data_q   <= '0;
            res_valid_q <= 1'b1;
            res_hit_q   <= 1'b1;
            res_mac_q   <= sha;
            state_q     <= StDone;
          end else if (out_r_TREADY) begin
            if (tx_idx_q == LAST_BYTE) begin
              tx_valid_q <= 1'b0;
              tx_last_q  <= 1'b0;
              tx_data_q  <= '0;
              timer_q    <= '0;
              state_q    <= StWait;
            end else begin
              tx_idx_q  <= tx_idx_q + 6'd1;
              tx_data_q <= arp_tx_byte(tx_idx_q + 6'd1, own_mac_q, own_ip_q, target_ip_q);
              tx_last_q <= ((tx_idx_q + 6'd1) == LAST_BYTE);
            end
          end
        end
        StWait: begin
          // A reply landing on the expiry cycle still wins.
          if (match) begin
            res_valid_q <= 1'b1;
            res_hit_q   <= 1'b1;
            res_mac_q   <= sha;
            state_q     <= StDone;
          end else if (timer_q == TimerLast) begin
            if (retries_q < RetryMax) begin
              retries_q  <= retries_q + 8'd1;
              tx_idx_q   <= '0;
              tx_valid_q <= 1'b1;
              tx_last_q  <= 1'b0;
              tx_data_q  <= arp_tx_byte(6'd0, own_mac_q, own_ip_q, target_ip_q);
              state_q    <= StSend;
            end else begin
              res_valid_q <= 1'b1;
              res_hit_q   <= 1'b0;
              res_mac_q   <= '0;
              state_q     <= StDone;
            end
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        StDone: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
